iir_biquad_sequencer: RTL



---
 rtl/iir_seq_pkg.sv | 34 +++
 rtl/iir_biquad_sequencer_if.sv | 28 ++
 rtl/iir_mac_unit.sv | 26 ++
 rtl/iir_biquad_sequencer.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/iir_seq_pkg.sv
// Shared types, constants and result narrowing for the biquad sequencer.
// Define IIR_SAT_EN to clamp each stage result; otherwise results wrap.
package iir_seq_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned PROD_W    = 32;
  localparam int unsigned ACC_W     = 36;
  localparam int unsigned FRAC_BITS = 14;
  localparam int unsigned NUM_TAPS  = 5;

  localparam logic signed [DATA_W-1:0] COEF_UNITY = 16'sd16384;

  localparam int unsigned B0 = 0;
  localparam int unsigned B1 = 1;
  localparam int unsigned B2 = 2;
  localparam int unsigned A1 = 3;
  localparam int unsigned A2 = 4;

  typedef enum logic [1:0] {IDLE, MAC, WB, DONE} state_t;

  // Drop the Q2.14 fraction (floor), then clamp or wrap to 16 bits.
  function automatic logic signed [DATA_W-1:0] narrow(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] sh;
    sh = acc >>> FRAC_BITS;
`ifdef IIR_SAT_EN
    if (sh > 36'sd32767)       return 16'sh7fff;
    else if (sh < -36'sd32768) return 16'sh8000;
    else                       return DATA_W'(sh);
`else
    return DATA_W'(sh);
`endif
  endfunction

endpackage

// File: rtl/iir_biquad_sequencer_if.sv
// Sample stream, status and coefficient-write bus of the biquad sequencer.
interface iir_biquad_sequencer_if
  import iir_seq_pkg::*;
#(
  parameter int unsigned COEF_AW = 5
);
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_sample;
  logic                     in_ready;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_sample;
  logic                     overrun;
  logic                     coef_we;
  logic [COEF_AW-1:0]       coef_addr;
  logic signed [DATA_W-1:0] coef_wdata;
  logic                     coef_commit;
  logic                     commit_pending;

  modport master (
    output in_valid, in_sample, coef_we, coef_addr, coef_wdata, coef_commit,
    input  in_ready, out_valid, out_sample, overrun, commit_pending
  );

  modport slave (
    input  in_valid, in_sample, coef_we, coef_addr, coef_wdata, coef_commit,
    output in_ready, out_valid, out_sample, overrun, commit_pending
  );
endinterface

// File: rtl/iir_mac_unit.sv
// Shared signed 16x16 multiplier with a 36-bit clear/add/subtract accumulator.
module iir_mac_unit
  import iir_seq_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     clr,
  input  logic                     sub,
  input  logic signed [DATA_W-1:0] coef,
  input  logic signed [DATA_W-1:0] data,
  output logic signed [ACC_W-1:0]  acc
);
  logic signed [PROD_W-1:0] prod_c;
  logic signed [ACC_W-1:0]  prod_ext_c;
  logic signed [ACC_W-1:0]  base_c;

  assign prod_c     = coef * data;
  assign prod_ext_c = {{(ACC_W-PROD_W){prod_c[PROD_W-1]}}, prod_c};
  assign base_c     = clr ? '0 : acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   acc <= '0;
    else if (en) acc <= sub ? (base_c - prod_ext_c) : (base_c + prod_ext_c);
  end
endmodule

// File: rtl/iir_biquad_sequencer.sv
// Time-multiplexed DF-I biquad cascade with shadow/active coefficient banks.
// Build option: IIR_SAT_EN selects saturating stage results (default wraps).
module iir_biquad_sequencer
  import iir_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned COEF_AW    = $clog2(5*NUM_STAGES)
)(
  input  logic                   clk,
  input  logic                   reset,
  iir_biquad_sequencer_if.slave  bus
);
  localparam int unsigned NUM_COEF = NUM_TAPS * NUM_STAGES;
  localparam int unsigned STAGE_W  = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  state_t state, state_nxt;
  logic [STAGE_W-1:0] stage;
  logic [2:0]         step;

  logic signed [DATA_W-1:0] shadow [NUM_COEF];
  logic signed [DATA_W-1:0] active [NUM_COEF];
  logic signed [DATA_W-1:0] x1 [NUM_STAGES];
  logic signed [DATA_W-1:0] x2 [NUM_STAGES];
  logic signed [DATA_W-1:0] y1 [NUM_STAGES];
  logic signed [DATA_W-1:0] y2 [NUM_STAGES];
  logic signed [DATA_W-1:0] cur_x;

  logic                     in_ready, out_valid, overrun, commit_pending;
  logic signed [DATA_W-1:0] out_sample;

  logic                     accept_c, mac_en_c, wb_en_c, last_c;
  logic [COEF_AW-1:0]       coef_sel_c;
  logic signed [DATA_W-1:0] mac_data_c;
  logic signed [DATA_W-1:0] y_c;
  logic signed [ACC_W-1:0]  acc;

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = out_valid;
  assign bus.out_sample     = out_sample;
  assign bus.overrun        = overrun;
  assign bus.commit_pending = commit_pending;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and per-cycle datapath strobes.
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    mac_en_c  = 1'b0;
    wb_en_c   = 1'b0;
    last_c    = (stage == STAGE_W'(NUM_STAGES-1));
    case (state)
      IDLE: if (bus.in_valid) begin
        accept_c  = 1'b1;
        state_nxt = MAC;
      end
      MAC: begin
        mac_en_c = 1'b1;
        if (step == 3'(A2)) state_nxt = WB;
      end
      WB: begin
        wb_en_c   = 1'b1;
        state_nxt = last_c ? DONE : MAC;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Tap operand selection: step order is b0,b1,b2,a1,a2.
  always_comb begin
    coef_sel_c = COEF_AW'(NUM_TAPS * 32'(stage) + 32'(step));
    mac_data_c = '0;
    case (step)
      3'(B0):  mac_data_c = cur_x;
      3'(B1):  mac_data_c = x1[stage];
      3'(B2):  mac_data_c = x2[stage];
      3'(A1):  mac_data_c = y1[stage];
      3'(A2):  mac_data_c = y2[stage];
      default: mac_data_c = '0;
    endcase
  end

  iir_mac_unit u_mac (
    .clk   (clk),
    .reset (reset),
    .en    (mac_en_c),
    .clr   (step == 3'(B0)),
    .sub   (step >= 3'(A1)),
    .coef  (active[coef_sel_c]),
    .data  (mac_data_c),
    .acc   (acc)
  );

  assign y_c = narrow(acc);

  // Sequencing, history and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage      <= '0;
      step       <= '0;
      cur_x      <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_sample <= '0;
      overrun    <= 1'b0;
      for (int i = 0; i < NUM_STAGES; i++) begin
        x1[i] <= '0;
        x2[i] <= '0;
        y1[i] <= '0;
        y2[i] <= '0;
      end
    end else begin
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
      if (bus.in_valid && state != IDLE) overrun <= 1'b1;
      if (accept_c) begin
        stage <= '0;
        step  <= '0;
        cur_x <= bus.in_sample;
      end
      if (mac_en_c) step <= step + 3'd1;
      if (wb_en_c) begin
        x2[stage] <= x1[stage];
        x1[stage] <= cur_x;
        y2[stage] <= y1[stage];
        y1[stage] <= y_c;
        cur_x     <= y_c;
        step      <= '0;
        if (last_c) out_sample <= y_c;
        else        stage      <= stage + STAGE_W'(1);
      end
    end
  end

  // Coefficient banks: the copy happens on any idle edge once a commit is pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      commit_pending <= 1'b0;
      for (int i = 0; i < NUM_COEF; i++) begin
        shadow[i] <= ((i % NUM_TAPS) == 0) ? COEF_UNITY : '0;
        active[i] <= ((i % NUM_TAPS) == 0) ? COEF_UNITY : '0;
      end
    end else begin
      if (bus.coef_we && (32'(bus.coef_addr) < NUM_COEF))
        shadow[bus.coef_addr] <= bus.coef_wdata;
      if (state == IDLE && commit_pending) active <= shadow;
      if (bus.coef_commit)    commit_pending <= 1'b1;
      else if (state == IDLE) commit_pending <= 1'b0;
    end
  end
endmodule
